// File: rtl/vjtag_led_pkg.sv
// rtl/vjtag_led_pkg.sv - shared opcodes, state/mode enums and widths for the vJTAG LED sequencer
package vjtag_led_pkg;

    localparam int LED_W = 7;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_SET    = 8'h01;
    localparam logic [7:0] OP_BLINK  = 8'h02;
    localparam logic [7:0] OP_ROTATE = 8'h03;
    localparam logic [7:0] OP_STOP   = 8'h04;

    typedef enum logic [1:0] {IDLE, ARG, APPLY} seq_state_t;
    typedef enum logic [1:0] {STATIC, BLINK, ROTATE} led_mode_t;

endpackage

// File: rtl/vjtag_led_sequencer_tick.sv
// rtl/vjtag_led_sequencer_tick.sv - display tick prescaler, one-cycle tick every TICK_DIV clocks
module vjtag_led_tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(TICK_DIV - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == CW'(TICK_DIV - 1));

endmodule

// File: rtl/vjtag_led_sequencer.sv
// rtl/vjtag_led_sequencer.sv - two-byte command FSM driving static/blink/rotate LED patterns
// Optional argument timeout: define VJTAG_LED_SEQ_TIMEOUT_EN.
module vjtag_led_sequencer
    import vjtag_led_pkg::*;
#(
    parameter int TICK_DIV       = 1_000_000,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_data,
    output logic             cmd_ready,
    output logic [LED_W-1:0] leds,
    output logic             busy,
    output logic             cmd_err
);

    seq_state_t       r_state, w_state_nxt;
    led_mode_t        r_mode, w_mode_nxt;
    logic [7:0]       r_opcode, r_arg;
    logic [7:0]       r_period, w_period_nxt;
    logic [7:0]       r_pcnt, w_pcnt_nxt;
    logic [LED_W-1:0] r_pattern, w_pattern_nxt;
    logic [LED_W-1:0] r_leds, w_leds_nxt;
    logic             r_phase, w_phase_nxt;
    logic             r_err, w_err_nxt;
    logic             w_accept, w_apply, w_tick, w_step, w_timeout;

    assign cmd_ready = (r_state != APPLY);
    assign busy      = (r_state != IDLE);
    assign cmd_err   = r_err;
    assign leds      = r_leds;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_apply   = (r_state == APPLY);
    assign w_step    = w_tick && ((r_pcnt + 8'd1) == r_period);

    vjtag_led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .rst   (rst),
        .clr   (w_apply),
        .tick  (w_tick)
    );

`ifdef VJTAG_LED_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Held at zero outside ARG so every ARG entry starts a fresh wait.
    always_ff @(posedge clock) begin
        if (rst || (r_state != ARG)) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ARG) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (cmd_data == OP_SET || cmd_data == OP_BLINK || cmd_data == OP_ROTATE) begin
                        w_state_nxt = ARG;
                    end else if (cmd_data == OP_STOP) begin
                        w_state_nxt = APPLY;
                    end else if (cmd_data != OP_NOP) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ARG: begin
                if (w_accept) begin
                    w_state_nxt = APPLY;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            APPLY:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // APPLY takes priority over a coincident step so a new command restarts timing cleanly.
    always_comb begin
        w_mode_nxt    = r_mode;
        w_pattern_nxt = r_pattern;
        w_period_nxt  = r_period;
        w_phase_nxt   = r_phase;
        w_pcnt_nxt    = r_pcnt;
        if (w_apply) begin
            w_pcnt_nxt  = 8'd0;
            w_phase_nxt = 1'b1;
            case (r_opcode)
                OP_SET: begin
                    w_pattern_nxt = r_arg[LED_W-1:0];
                    w_mode_nxt    = STATIC;
                end
                OP_BLINK: begin
                    w_period_nxt = (r_arg == 8'd0) ? 8'd1 : r_arg;
                    w_mode_nxt   = BLINK;
                end
                OP_ROTATE: begin
                    w_period_nxt = (r_arg == 8'd0) ? 8'd1 : r_arg;
                    w_mode_nxt   = ROTATE;
                end
                OP_STOP: w_mode_nxt = STATIC;
                default: ;
            endcase
        end else if (w_tick) begin
            if (w_step) begin
                w_pcnt_nxt = 8'd0;
                case (r_mode)
                    BLINK:   w_phase_nxt   = ~r_phase;
                    ROTATE:  w_pattern_nxt = {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
                    default: ;
                endcase
            end else begin
                w_pcnt_nxt = r_pcnt + 8'd1;
            end
        end
        w_leds_nxt = ((w_mode_nxt == BLINK) && !w_phase_nxt) ? '0 : w_pattern_nxt;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mode    <= STATIC;
            r_opcode  <= 8'h00;
            r_arg     <= 8'h00;
            r_period  <= 8'd1;
            r_pcnt    <= 8'd0;
            r_pattern <= '0;
            r_phase   <= 1'b1;
            r_leds    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_period  <= w_period_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_pattern <= w_pattern_nxt;
            r_phase   <= w_phase_nxt;
            r_leds    <= w_leds_nxt;
            r_err     <= w_err_nxt;
            if (w_accept && r_state == IDLE) begin
                r_opcode <= cmd_data;
            end
            if (w_accept && r_state == ARG) begin
                r_arg <= cmd_data;
            end
        end
    end

endmodule

// File: tb/tb_vjtag_led_sequencer.sv
// tb/tb_vjtag_led_sequencer.sv - scoreboard bench: expected LED changes and cmd_err pulses with cycle stamps
module tb_vjtag_led_sequencer;

    logic       clock;
    logic       rst;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic [6:0] leds;
    logic       busy;
    logic       cmd_err;

    vjtag_led_sequencer #(.TICK_DIV(4), .TIMEOUT_CYCLES(20)) dut (
        .clock     (clock),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .leds      (leds),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    typedef struct {
        logic [6:0] val;
        int         cyc;
    } ev_t;

    ev_t        led_q[$];
    int         err_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    bit         mon_en = 0;
    logic [6:0] last_leds;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    // Monitor: every LED change and every cmd_err pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (mon_en) begin
            if (leds !== last_leds) begin
                n_cmp++;
                if (led_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL leds_unexpected: got %h at cycle %0d, required no change from %h",
                             leds, cyc, last_leds);
                end else begin
                    ev_t e;
                    e = led_q.pop_front();
                    if (leds !== e.val || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL leds_event: got %h at cycle %0d, required %h at cycle %0d",
                                 leds, cyc, e.val, e.cyc);
                    end
                end
                last_leds = leds;
            end
            if (cmd_err !== 1'b0) begin
                n_cmp++;
                if (err_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL err_unexpected: got cmd_err=%b at cycle %0d, required 0", cmd_err, cyc);
                end else begin
                    int ec;
                    ec = err_q.pop_front();
                    if (cmd_err !== 1'b1 || cyc != ec) begin
                        n_fail++;
                        $display("FAIL err_event: got cmd_err=%b at cycle %0d, required pulse at cycle %0d",
                                 cmd_err, cyc, ec);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Returns the cycle stamp of the clock edge that accepted the byte.
    task automatic send(input logic [7:0] b, output int t);
        int guard;
        guard = 0;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (cmd_ready !== 1'b1 && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 10) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_ready: got cmd_ready=%b for 10 cycles, required 1", cmd_ready);
        end
        @(posedge clock);
        #1;
        t         = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_led(input logic [6:0] v, input int c);
        ev_t e;
        e.val = v;
        e.cyc = c;
        led_q.push_back(e);
    endtask

    initial begin
        int t, r, s, b, u;
        logic [6:0] rot;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_leds", {25'd0, leds}, 32'h00);
        chk("reset_ready", {31'd0, cmd_ready}, 32'h1);
        chk("reset_busy", {31'd0, busy}, 32'h0);
        chk("reset_err", {31'd0, cmd_err}, 32'h0);
        @(negedge clock);
        rst       = 1'b0;
        last_leds = 7'h00;
        mon_en    = 1'b1;

        // SET 0x55, then hold static
        send(8'h01, t);
        send(8'h55, t);
        push_led(7'h55, t + 1);
        wait_until(t + 101);

        // BLINK period 2: 8 clocks on, 8 clocks off
        send(8'h02, t);
        send(8'h02, t);
        push_led(7'h00, t + 9);
        push_led(7'h55, t + 17);
        push_led(7'h00, t + 25);
        push_led(7'h55, t + 33);
        wait_until(t + 34);

        // SET 0x41 then ROTATE period 1: seven steps return to 0x41
        send(8'h01, t);
        send(8'h41, t);
        push_led(7'h41, t + 1);
        send(8'h03, r);
        send(8'h01, r);
        rot = 7'h41;
        for (int k = 1; k <= 7; k++) begin
            rot = {rot[5:0], rot[6]};
            push_led(rot, r + 1 + 4 * k);
        end
        wait_until(r + 30);

        // STOP freezes rotation on the current pattern
        send(8'h04, s);
        wait_until(s + 40);

        // BLINK with argument 0 behaves as period 1
        send(8'h02, b);
        send(8'h00, b);
        push_led(7'h00, b + 5);
        push_led(7'h41, b + 9);
        push_led(7'h00, b + 13);
        wait_until(b + 14);
        send(8'h01, t);
        send(8'h00, t);

        // ROTATE on an all-zero pattern stays dark
        send(8'h03, t);
        send(8'h00, t);
        wait_until(t + 30);

        // Unknown opcodes pulse cmd_err once each; NOP is silent
        send(8'h7F, u);
        err_q.push_back(u);
        @(negedge clock);
        chk("unknown_busy", {31'd0, busy}, 32'h0);
        send(8'h05, u);
        err_q.push_back(u);
        send(8'h00, u);
        @(negedge clock);
        chk("nop_busy", {31'd0, busy}, 32'h0);
        wait_until(u + 10);

        // Argument timeout behaviour
        send(8'h01, t);
        @(negedge clock);
        chk("arg_busy", {31'd0, busy}, 32'h1);
`ifdef VJTAG_LED_SEQ_TIMEOUT_EN
        err_q.push_back(t + 20);
        wait_until(t + 22);
        @(negedge clock);
        chk("timeout_busy", {31'd0, busy}, 32'h0);
        send(8'h55, u);
        err_q.push_back(u);
`else
        wait_until(t + 22);
        @(negedge clock);
        chk("no_timeout_busy", {31'd0, busy}, 32'h1);
        send(8'h55, u);
        push_led(7'h55, u + 1);
`endif
        wait_until(u + 12);

        chk("led_queue_drained", led_q.size(), 32'd0);
        chk("err_queue_drained", err_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
